hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Hazard and flush controller for the 5-stage pipeline.
- Detects load-use hazards between the instruction in ID and a load in EX. Sequences flush windows for taken branches (resolved in EX) and jumps (resolved in ID).
- Drives the Load_Use/Branch_fc/Jump_fc inputs of the ID/EX segment register and the IF/ID and PC write enables.
- Keeps saturating stall and flush performance counters.

Parameters:
- FLUSH_CYCLES, 1: extra flush cycles held after a taken branch, beyond the resolving cycle. Legal range 0..3.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  pipeline clock; state updates on posedge.
- rst  in  1  synchronous active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_use_rs  in  1  the ID instruction reads rs.
- id_use_rt  in  1  the ID instruction reads rt.
- ex_memread  in  1  MemRead output of the ID/EX register.
- ex_rt  in  5  rt output of the ID/EX register (load destination).
- branch_taken  in  1  branch in EX resolved taken this cycle.
- jump_id  in  1  jump decoded in ID this cycle.
- Load_Use  out  1  bubble request to ID/EX.
- Branch_fc  out  1  branch flush to ID/EX.
- Jump_fc  out  1  jump flush to ID/EX.
- pc_wr  out  1  PC write enable.
- ifid_wr  out  1  IF/ID write enable.
- ifid_flush  out  1  clear IF/ID.
- stall_cnt  out  CNT_W  load-use stall cycles.
- flush_cnt  out  CNT_W  branch+jump flush events.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Outputs Load_Use, Branch_fc, Jump_fc, pc_wr, ifid_wr, ifid_flush are combinational from the registered state and the current inputs. They are stable before the negedge at which ID/EX samples.
- Reset (posedge with rst=1): state<=RUN, flush counter fc<=0, stall_cnt<=0, flush_cnt<=0.
- Output values while rst=1: Load_Use=0, Branch_fc=0, Jump_fc=0, pc_wr=1, ifid_wr=1, ifid_flush=0.
- Hazard term: hz = ex_memread && ex_rt!=0 && ((id_use_rs && id_rs==ex_rt) || (id_use_rt && id_rt==ex_rt)).
- States: RUN, STALL, BFLUSH.
- RUN, priority order branch > jump > load-use:
  - branch_taken: Branch_fc=1, ifid_flush=1, pc_wr=1. Next state BFLUSH with fc<=FLUSH_CYCLES if FLUSH_CYCLES>0, else RUN. flush_cnt+1.
  - else jump_id: Jump_fc=1, ifid_flush=1, pc_wr=1. Stay in RUN. flush_cnt+1.
  - else hz: Load_Use=1, pc_wr=0, ifid_wr=0. Next state STALL. stall_cnt+1.
  - else all flush and stall outputs 0, pc_wr=ifid_wr=1.
- STALL: lasts exactly one cycle; hz is ignored in this state.
  - branch_taken still wins and is handled as in RUN.
  - Otherwise all flush and stall outputs 0, and next state is RUN.
- BFLUSH: Branch_fc=1, ifid_flush=1, pc_wr=1, and fc decrements each cycle.
  - Return to RUN when fc==1 at posedge.
  - jump_id and hz are suppressed; the flushed instructions are invalid.
  - A new branch_taken during BFLUSH reloads fc<=FLUSH_CYCLES and counts a new flush event.
- Simultaneous branch_taken with jump_id or hz: branch only. One flush_cnt increment, no stall_cnt increment.
- Counters saturate at all-ones with no wrap. They increment only on the cycle an event is accepted.
- rst asserted mid-BFLUSH or mid-STALL: returns to RUN at that posedge. Pending flush cycles are dropped.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding constants ST_RUN=2'd0, ST_STALL=2'd1, ST_BFLUSH=2'd2;
  - the REG_ZERO=5'd0 constant.
- One sub-module, sat_counter (CNT_W, inc, rst), is instantiated twice for the performance counters.
- The hazard compare stays inline.

Test Plan:
1. lw $5 in EX (ex_memread=1, ex_rt=5), ID add with id_rs=5, id_use_rs=1.
   -> Cycle 1: Load_Use=1, pc_wr=0, ifid_wr=0, stall_cnt=1.
   -> Cycle 2 (STALL): all outputs 0, pc_wr=1, even with hz still true.
2. ex_rt=0, ex_memread=1, id_rs=0 -> no stall; stall_cnt stays 0.
3. FLUSH_CYCLES=1, branch_taken pulse one cycle -> Branch_fc=1 for 2 cycles, ifid_flush=1 for 2 cycles, flush_cnt=1, then RUN.
4. branch_taken, jump_id and hz all asserted in the same RUN cycle -> only Branch_fc and ifid_flush asserted; flush_cnt=1, stall_cnt=0.
5. CNT_W=4, 20 consecutive jump_id cycles -> flush_cnt saturates at 15.
6. rst=1 during BFLUSH cycle 1 -> next cycle Branch_fc=0, counters 0, state RUN.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the hazard/flush controller.
//   - ctrl_state_t : hazard controller state encoding
//   - REG_ZERO     : register $0, never a real dependency source
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_BFLUSH = 2'd2
  } ctrl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
//   clk : clock (posedge)
//   rst : synchronous active-high clear
//   inc : count one event this cycle
//   cnt : current count, holds at all-ones
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and flush controller for the 5-stage pipeline.
// Detects load-use hazards (ID vs load in EX), sequences branch flush
// windows (resolved in EX) and jump flushes (resolved in ID), and keeps
// saturating stall/flush event counters.
//   clk, rst                   : clock, synchronous active-high reset
//   id_rs/id_rt, id_use_rs/rt  : source registers of the ID instruction
//   ex_memread, ex_rt          : load in EX and its destination
//   branch_taken, jump_id      : control-flow redirects
//   Load_Use/Branch_fc/Jump_fc : ID/EX bubble and flush controls
//   pc_wr, ifid_wr, ifid_flush : PC and IF/ID controls
//   stall_cnt, flush_cnt       : performance counters
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic             jump_id,
  output logic             Load_Use,
  output logic             Branch_fc,
  output logic             Jump_fc,
  output logic             pc_wr,
  output logic             ifid_wr,
  output logic             ifid_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] FC_LOAD = 2'(FLUSH_CYCLES);

  ctrl_state_t state, state_nx;
  logic [1:0]  fc, fc_nx;
  logic        hz;
  logic        stall_inc, flush_inc;

  assign hz = ex_memread && (ex_rt != REG_ZERO) &&
              ((id_use_rs && (id_rs == ex_rt)) ||
               (id_use_rt && (id_rt == ex_rt)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      fc    <= '0;
    end else begin
      state <= state_nx;
      fc    <= fc_nx;
    end
  end

  always_comb begin
    Load_Use   = 1'b0;
    Branch_fc  = 1'b0;
    Jump_fc    = 1'b0;
    pc_wr      = 1'b1;
    ifid_wr    = 1'b1;
    ifid_flush = 1'b0;
    state_nx   = state;
    fc_nx      = fc;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;

    if (!rst) begin
      unique case (state)
        ST_RUN, ST_STALL: begin
          if (branch_taken) begin
            Branch_fc  = 1'b1;
            ifid_flush = 1'b1;
            flush_inc  = 1'b1;
            if (FLUSH_CYCLES > 0) begin
              state_nx = ST_BFLUSH;
              fc_nx    = FC_LOAD;
            end else begin
              state_nx = ST_RUN;
            end
          end else if (state == ST_STALL) begin
            // Bubble already inserted; hz is stale this cycle.
            state_nx = ST_RUN;
          end else if (jump_id) begin
            Jump_fc    = 1'b1;
            ifid_flush = 1'b1;
            flush_inc  = 1'b1;
          end else if (hz) begin
            Load_Use  = 1'b1;
            pc_wr     = 1'b0;
            ifid_wr   = 1'b0;
            stall_inc = 1'b1;
            state_nx  = ST_STALL;
          end
        end
        ST_BFLUSH: begin
          Branch_fc  = 1'b1;
          ifid_flush = 1'b1;
          if (branch_taken) begin
            fc_nx     = FC_LOAD;
            flush_inc = 1'b1;
          end else begin
            fc_nx = fc - 2'd1;
            if (fc == 2'd1) begin
              state_nx = ST_RUN;
            end
          end
        end
        default: begin
          state_nx = ST_RUN;
          fc_nx    = '0;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .cnt (flush_cnt)
  );

endmodule
